// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the front-end pipeline stages.
package cpu_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;
  localparam logic [3:0]  OPC_HALT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IDLE/RUN/DONE control and the IF/ID output register.
// Optional halt-opcode detection is enabled by defining FETCH_HALT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned        IMEM_DEPTH = 25,
  parameter logic [PC_W-1:0]    RESET_PC   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [PC_W-1:0]       im_pc,
  input  logic [INSTR_W-1:0]    im_instr,
  input  logic                  redirect_valid,
  input  logic [PC_W-1:0]       redirect_pc,
  output logic [INSTR_W-1:0]    instr_out,
  output logic [PC_W-1:0]       pc_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  done
);

  localparam logic [PC_W-1:0] DepthPc = PC_W'(IMEM_DEPTH);

  fetch_state_t       r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc_out;
  logic               r_valid;
  logic               r_done;

  logic w_pc_in_range;
  logic w_tgt_in_range;
  logic w_load;
  logic w_halt;

  assign w_pc_in_range  = (r_pc < DepthPc);
  assign w_tgt_in_range = (redirect_pc < DepthPc);
  assign w_load = (r_state == RUN) && w_pc_in_range && (!r_valid || ready_in) && !redirect_valid;

`ifdef FETCH_HALT_EN
  assign w_halt = (im_instr[15:12] == OPC_HALT);
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_done  <= 1'b0;
          end
        end
        RUN, DONE: begin
          if (redirect_valid) begin
            // Flush wins over any same-cycle transfer or load.
            r_pc    <= redirect_pc;
            r_valid <= 1'b0;
            r_state <= w_tgt_in_range ? RUN : DONE;
            r_done  <= !w_tgt_in_range;
          end else if (w_load) begin
            r_instr  <= im_instr;
            r_pc_out <= r_pc;
            r_valid  <= 1'b1;
            r_pc     <= r_pc + 1'b1;
            if (w_halt) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end else begin
            if (r_valid && ready_in) begin
              r_valid <= 1'b0;
            end
            if (r_state == RUN && !w_pc_in_range) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign im_pc     = r_pc;
  assign instr_out = r_instr;
  assign pc_out    = r_pc_out;
  assign valid_out = r_valid;
  assign done      = r_done;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction memory `im`. Owns the 16-bit program counter and drives `im`'s `pc` input. Captures `im`'s combinational instruction word into an IF/ID output register. Hands it to decode over a valid/ready handshake, with support for stalls, branch redirects and end-of-program detection.

## Interface
Parameters:
- `IMEM_DEPTH`, 25 — number of valid instruction words; PC values ≥ this are end-of-program.
- `RESET_PC`, 16'h0000 — PC loaded on reset.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — leave IDLE and begin fetching.
- `im_pc` out 16 — address to `im.pc`; equals the PC register.
- `im_instr` in 16 — `im.out`, combinational from `im_pc`.
- `redirect_valid` in 1 — branch/jump taken this cycle.
- `redirect_pc` in 16 — redirect target.
- `instr_out` out 16 — IF/ID instruction register.
- `pc_out` out 16 — address of `instr_out`.
- `valid_out` out 1 — IF/ID register holds a live instruction.
- `ready_in` in 1 — decode accepts this cycle.
- `done` out 1 — fetch has stopped (end of program or halt).

## Operation
- States:
  - IDLE: no fetch. Goes to RUN when `start`=1.
  - RUN: fetching.
  - DONE: stopped. Goes to RUN when a redirect arrives with `redirect_pc` < `IMEM_DEPTH`.
- `done` = 1 exactly in DONE.
- Load condition: `load` = RUN & (PC < `IMEM_DEPTH`) & (!`valid_out` | `ready_in`) & !`redirect_valid`.
- On `load`:
  - `instr_out` ← `im_instr`; `pc_out` ← PC; `valid_out` ← 1; PC ← PC+1.
  - PC wraps modulo 2^16.
- Transfer to decode occurs when `valid_out` & `ready_in`.
  - If a transfer happens with no load, `valid_out` ← 0.
- Stall (`valid_out`=1, `ready_in`=0): IF/ID register and PC hold, and `im_pc` stays stable.
- Redirect (`redirect_valid`=1, any state except IDLE):
  - PC ← `redirect_pc`.
  - `valid_out` ← 0 (flush), even when `ready_in`=1 in the same cycle. Decode must not count that cycle's transfer.
  - A target ≥ `IMEM_DEPTH` moves to DONE. Any other target moves to RUN.
  - Redirect has priority over load and stall.
- End of program: in RUN, when PC = `IMEM_DEPTH` and no redirect, move to DONE. The last loaded word still drains normally.
- Redirect in IDLE is ignored.
- `im_instr` bits that are X/don't-care pass through unmodified.

## Timing
- Reset values:
  - Outputs: `instr_out`=0, `pc_out`=0, `valid_out`=0, `done`=0.
  - Internal: PC=`RESET_PC`, state IDLE.
- Reset mid-operation discards the IF/ID contents on the next edge.
- `start` asserted in cycle n: state is RUN in n+1, and the first load happens at the end of n+1.
- Fetch latency: PC presented in cycle k, so `valid_out`/`instr_out` are visible in k+1.
- Throughput: one instruction per cycle while `ready_in`=1.
- Redirect in cycle k: `im_pc`=target in k+1, and the target instruction is valid in k+2. This gives one bubble cycle.

## Configuration
- `FETCH_HALT_EN` defined:
  - A loaded word with `im_instr[15:12]` = 4'b1111 is a halt.
  - The halt word itself is delivered normally.
  - State → DONE at the same edge, and PC is frozen at halt address + 1.
- `FETCH_HALT_EN` undefined: opcode 4'b1111 is fetched like any other word. Fetch stops only at `IMEM_DEPTH` or via a redirect target.

## Structure
- Shared package `cpu_pkg`:
  - State enum `fetch_state_t` (IDLE, RUN, DONE).
  - Constants `PC_W`=16, `INSTR_W`=16, `OPC_HALT`=4'b1111.
- No sub-module: the PC register, FSM and IF/ID register are all in `fetch_unit`.
- `im` is instantiated by the parent, not inside this block.

## Test plan
- Reset, then `start`, with `ready_in`=1 and real `im`: consecutive cycles give `pc_out`/`instr_out` = 0/16'h012F, 1/16'h012E, 2/16'h034C.
- Hold `ready_in`=0 for 3 cycles while `pc_out`=2: `instr_out` holds 16'h034C, `im_pc` stays 3, and there is exactly one transfer once `ready_in` returns.
- `redirect_valid` with `redirect_pc`=22 while `valid_out`=1: the next cycle has `valid_out`=0, and the cycle after has `pc_out`=22, `instr_out`=16'h0CCF.
- Run to the end: after `pc_out`=24/16'h0CDF, `done`=1, and `valid_out` drops after consumption. Then redirect to 0: RUN resumes and delivers 16'h012F.
- With `FETCH_HALT_EN`, force `im_instr`=16'hF000 at PC 5: the word is delivered with `pc_out`=5, then `done`=1 and `im_pc` is frozen at 6. Without the macro, fetch continues to PC 6.
- Assert `rst` for one cycle mid-stream with `valid_out`=1: the next cycle has `valid_out`=0, PC=0, and the state is IDLE until `start`.
